pipeline_hazard_sequencer: RTL

- Central sequencing block for the 16-bit five-stage pipeline: fetch, decode, execute, mem, writeback.
- Drives the PC write enable and the write/clear inputs of every inter-stage register (fd, de, em, mw).
- Implements power-up fill, load-use stall, taken-branch flush, memory-busy freeze and halt-drain.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_hazard_sequencer_if.sv | 41 ++++
 rtl/pipeline_hazard_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_sequencer_if.sv
// Control bundle between the hazard sequencer and the 16-bit pipeline.
// The master is the datapath side and the slave is the sequencer.
interface pipeline_hazard_sequencer_if #(
    parameter int REG_ADDR_W = 4
);
    logic                  dec_valid;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic                  dec_uses_rs1;
    logic                  dec_uses_rs2;
    logic                  dec_halt;
    logic                  ex_memread;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_branch_taken;
    logic                  mem_busy;
    logic                  pcwrite;
    logic                  pc_sel;
    logic                  fd_write;
    logic                  fd_flush;
    logic                  de_write;
    logic                  de_flush;
    logic                  em_write;
    logic                  em_flush;
    logic                  mw_write;
    logic                  halted;
    logic [15:0]           stall_count;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
        output dec_halt, ex_memread, ex_rd, ex_branch_taken, mem_busy,
        input  pcwrite, pc_sel, fd_write, fd_flush, de_write, de_flush,
        input  em_write, em_flush, mw_write, halted, stall_count
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
        input  dec_halt, ex_memread, ex_rd, ex_branch_taken, mem_busy,
        output pcwrite, pc_sel, fd_write, fd_flush, de_write, de_flush,
        output em_write, em_flush, mw_write, halted, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline sequencer: power-up fill, load-use stall, branch flush,
// memory freeze and halt drain for the five-stage pipe.
module pipeline_hazard_sequencer #(
    parameter int REG_ADDR_W   = 4,
    parameter int INIT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 4
) (
    input logic clock,
    input logic reset,
    pipeline_hazard_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  init_cnt;
    logic [3:0]  init_next;
    logic [2:0]  drain_cnt;
    logic [2:0]  drain_next;
    logic [15:0] stall_count;
    logic        halted;
    logic        stall_inc;
    logic        load_use;

    logic pcwrite;
    logic pc_sel;
    logic fd_write;
    logic fd_flush;
    logic de_write;
    logic de_flush;
    logic em_write;
    logic em_flush;
    logic mw_write;

    // Register 0 is hardwired, so a load into it never creates a hazard.
    assign load_use = bus.dec_valid & bus.ex_memread
                    & (bus.ex_rd != REG_ADDR_W'(0))
                    & ((bus.dec_uses_rs1 & (bus.dec_rs1 == bus.ex_rd))
                     | (bus.dec_uses_rs2 & (bus.dec_rs2 == bus.ex_rd)));

    // State, counters, halted flag and saturating stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_INIT;
            init_cnt    <= 4'(INIT_CYCLES - 1);
            drain_cnt   <= 3'd0;
            stall_count <= 16'd0;
            halted      <= 1'b0;
        end else begin
            state     <= state_next;
            init_cnt  <= init_next;
            drain_cnt <= drain_next;
            halted    <= (state_next == S_HALTED);
            if (stall_inc && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

    // Next state and Mealy control outputs.
    always_comb begin
        state_next = state;
        init_next  = init_cnt;
        drain_next = drain_cnt;
        stall_inc  = 1'b0;
        pcwrite    = 1'b0;
        pc_sel     = 1'b0;
        fd_write   = 1'b0;
        fd_flush   = 1'b0;
        de_write   = 1'b0;
        de_flush   = 1'b0;
        em_write   = 1'b0;
        em_flush   = 1'b0;
        mw_write   = 1'b0;
        unique case (state)
            S_INIT: begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
                em_flush = 1'b1;
                if (init_cnt == 4'd0) state_next = S_RUN;
                else init_next = init_cnt - 4'd1;
            end
            S_RUN: begin
                if (bus.mem_busy) begin
                    stall_inc = 1'b1;
                end else if (bus.ex_branch_taken) begin
                    pcwrite  = 1'b1;
                    pc_sel   = 1'b1;
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                    em_write = 1'b1;
                    mw_write = 1'b1;
                end else if (load_use) begin
                    de_flush  = 1'b1;
                    em_write  = 1'b1;
                    mw_write  = 1'b1;
                    stall_inc = 1'b1;
                end else if (bus.dec_valid && bus.dec_halt) begin
                    fd_flush   = 1'b1;
                    de_write   = 1'b1;
                    em_write   = 1'b1;
                    mw_write   = 1'b1;
                    state_next = S_DRAIN;
                    drain_next = 3'(DRAIN_CYCLES - 1);
                end else begin
                    pcwrite  = 1'b1;
                    fd_write = 1'b1;
                    de_write = 1'b1;
                    em_write = 1'b1;
                    mw_write = 1'b1;
                end
            end
            S_DRAIN: begin
                fd_flush = 1'b1;
                if (!bus.mem_busy) begin
                    de_write = 1'b1;
                    em_write = 1'b1;
                    mw_write = 1'b1;
                    if (drain_cnt == 3'd0) state_next = S_HALTED;
                    else drain_next = drain_cnt - 3'd1;
                end
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    assign bus.pcwrite     = pcwrite;
    assign bus.pc_sel      = pc_sel;
    assign bus.fd_write    = fd_write;
    assign bus.fd_flush    = fd_flush;
    assign bus.de_write    = de_write;
    assign bus.de_flush    = de_flush;
    assign bus.em_write    = em_write;
    assign bus.em_flush    = em_flush;
    assign bus.mw_write    = mw_write;
    assign bus.halted      = halted;
    assign bus.stall_count = stall_count;
endmodule
